// File: rtl/spgd_pkg.sv
// Shared constants and types for the SPGD perturbation sequencer and its metric averager.
package spgd_pkg;

  localparam int unsigned METRIC_W_DEF = 32;
  localparam int unsigned STATE_W      = 3;

  localparam logic [1:0] DAC_SEL_ZERO  = 2'b00;
  localparam logic [1:0] DAC_SEL_PLUS  = 2'b01;
  localparam logic [1:0] DAC_SEL_MINUS = 2'b10;
  localparam logic [1:0] DAC_SEL_NOM   = 2'b11;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_SETTLE_P = 3'd1,
    ST_ACC_P    = 3'd2,
    ST_SETTLE_M = 3'd3,
    ST_ACC_M    = 3'd4,
    ST_UPDATE   = 3'd5
  } state_t;

  // Limit the requested averaging exponent to what the accumulator can hold.
  function automatic logic [3:0] clamp_shift(input logic [3:0] shift, input logic [3:0] max_shift);
    return (shift > max_shift) ? max_shift : shift;
  endfunction

endpackage

// File: rtl/spgd_metric_avg.sv
// Power-of-two metric averager shared by the U+ and U- phases; done/avg are combinational
// so the sequencer can take the result on the edge that accepts the last sample.
module spgd_metric_avg
  import spgd_pkg::*;
#(
  parameter int unsigned METRIC_W      = METRIC_W_DEF,
  parameter int unsigned MAX_AVG_SHIFT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                en,
  input  logic                valid,
  input  logic [METRIC_W-1:0] sample,
  input  logic [3:0]          shift,
  output logic                done_c,
  output logic [METRIC_W-1:0] avg_c
);

  localparam int unsigned ACC_W = METRIC_W + MAX_AVG_SHIFT;
  localparam int unsigned CNT_W = MAX_AVG_SHIFT + 1;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum_c;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last_c;

  assign sum_c  = acc + ACC_W'(sample);
  assign last_c = (CNT_W'(1) << shift) - CNT_W'(1);
  assign done_c = en && valid && (cnt == last_c);
  assign avg_c  = METRIC_W'(sum_c >> shift);

  always_ff @(posedge clk) begin
    if (rst || clear || done_c) begin
      acc <= '0;
      cnt <= '0;
    end else if (en && valid) begin
      acc <= sum_c;
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spgd_dac_sequencer.sv
// SPGD iteration sequencer: drives the DAC select through U+/U- settle and averaging phases,
// then presents J+/J-/delta to the gradient-update engine with a req/ack handshake.
module spgd_dac_sequencer
  import spgd_pkg::*;
#(
  parameter int unsigned METRIC_W      = METRIC_W_DEF,
  parameter int unsigned SETTLE_W      = 16,
  parameter int unsigned MAX_AVG_SHIFT = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ENABLE,
  input  logic                START,
  input  logic                CONTINUOUS,
  input  logic                STOP,
  input  logic [SETTLE_W-1:0] SETTLE_CYCLES,
  input  logic [3:0]          AVG_SHIFT,
  input  logic [METRIC_W-1:0] METRIC_IN,
  input  logic                METRIC_VALID,
  input  logic                UPDATE_ACK,
  output logic [1:0]          DAC_SEL,
  output logic [METRIC_W-1:0] J_PLUS,
  output logic [METRIC_W-1:0] J_MINUS,
  output logic [METRIC_W:0]   DELTA_J,
  output logic                UPDATE_REQ,
  output logic                BUSY,
  output logic                ITER_DONE
);

  state_t              state;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [SETTLE_W-1:0] settle_lat;
  logic [3:0]          shift_lat;
  logic                cont_lat;
  logic                run_active;
  logic                stop_pending;
  logic                ran;
  logic                acc_en_c;
  logic                avg_done_c;
  logic [METRIC_W-1:0] avg_c;

  assign acc_en_c = (state == ST_ACC_P) || (state == ST_ACC_M);

  spgd_metric_avg #(
    .METRIC_W      (METRIC_W),
    .MAX_AVG_SHIFT (MAX_AVG_SHIFT)
  ) u_avg (
    .clk    (CLK),
    .rst    (RST),
    .clear  (!ENABLE),
    .en     (acc_en_c),
    .valid  (METRIC_VALID),
    .sample (METRIC_IN),
    .shift  (shift_lat),
    .done_c (avg_done_c),
    .avg_c  (avg_c)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= ST_IDLE;
      DAC_SEL      <= DAC_SEL_ZERO;
      J_PLUS       <= '0;
      J_MINUS      <= '0;
      DELTA_J      <= '0;
      UPDATE_REQ   <= 1'b0;
      BUSY         <= 1'b0;
      ITER_DONE    <= 1'b0;
      settle_cnt   <= '0;
      settle_lat   <= '0;
      shift_lat    <= '0;
      cont_lat     <= 1'b0;
      run_active   <= 1'b0;
      stop_pending <= 1'b0;
      ran          <= 1'b0;
    end else if (!ENABLE) begin
      // Results are kept so the update engine can still read the last good pair.
      state        <= ST_IDLE;
      DAC_SEL      <= DAC_SEL_ZERO;
      UPDATE_REQ   <= 1'b0;
      BUSY         <= 1'b0;
      ITER_DONE    <= 1'b0;
      settle_cnt   <= '0;
      run_active   <= 1'b0;
      stop_pending <= 1'b0;
      ran          <= 1'b0;
    end else begin
      ITER_DONE <= 1'b0;
      if (STOP && run_active) stop_pending <= 1'b1;
      case (state)
        ST_IDLE: begin
          DAC_SEL <= ran ? DAC_SEL_NOM : DAC_SEL_ZERO;
          if (START) begin
            state        <= ST_SETTLE_P;
            DAC_SEL      <= DAC_SEL_PLUS;
            BUSY         <= 1'b1;
            settle_cnt   <= SETTLE_CYCLES;
            settle_lat   <= SETTLE_CYCLES;
            shift_lat    <= clamp_shift(AVG_SHIFT, 4'(MAX_AVG_SHIFT));
            cont_lat     <= CONTINUOUS;
            run_active   <= 1'b1;
            stop_pending <= STOP;
          end
        end
        ST_SETTLE_P: begin
          if (settle_cnt == '0) state <= ST_ACC_P;
          else settle_cnt <= settle_cnt - SETTLE_W'(1);
        end
        ST_ACC_P: begin
          if (avg_done_c) begin
            J_PLUS     <= avg_c;
            state      <= ST_SETTLE_M;
            DAC_SEL    <= DAC_SEL_MINUS;
            settle_cnt <= settle_lat;
          end
        end
        ST_SETTLE_M: begin
          if (settle_cnt == '0) state <= ST_ACC_M;
          else settle_cnt <= settle_cnt - SETTLE_W'(1);
        end
        ST_ACC_M: begin
          if (avg_done_c) begin
            J_MINUS    <= avg_c;
            DELTA_J    <= {1'b0, J_PLUS} - {1'b0, avg_c};
            state      <= ST_UPDATE;
            DAC_SEL    <= DAC_SEL_NOM;
            UPDATE_REQ <= 1'b1;
          end
        end
        ST_UPDATE: begin
          if (UPDATE_ACK) begin
            UPDATE_REQ <= 1'b0;
            ITER_DONE  <= 1'b1;
            ran        <= 1'b1;
            // A STOP arriving on the ack cycle still ends the run here.
            if (cont_lat && !(stop_pending || STOP)) begin
              state      <= ST_SETTLE_P;
              DAC_SEL    <= DAC_SEL_PLUS;
              settle_cnt <= settle_lat;
            end else begin
              state        <= ST_IDLE;
              DAC_SEL      <= DAC_SEL_NOM;
              BUSY         <= 1'b0;
              run_active   <= 1'b0;
              stop_pending <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spgd_dac_sequencer.sv
// Randomized bench for spgd_dac_sequencer against a phase-level averaging model.
`timescale 1ns/1ps
module tb_spgd_dac_sequencer;

  logic        clk = 1'b0;
  logic        rst, enable, start, continuous, stop;
  logic [15:0] settle_cycles;
  logic [3:0]  avg_shift;
  logic [31:0] metric_in;
  logic        metric_valid, update_ack;
  logic [1:0]  dac_sel;
  logic [31:0] j_plus, j_minus;
  logic [32:0] delta_j;
  logic        update_req, busy, iter_done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_jp = '0;
  logic [31:0] exp_jm = '0;
  logic [32:0] exp_dj = '0;
  int plus_len, minus_len;
  logic [31:0] pvals[$];
  logic [31:0] mvals[$];

  always #5 clk = ~clk;

  spgd_dac_sequencer dut (
    .CLK(clk), .RST(rst), .ENABLE(enable), .START(start), .CONTINUOUS(continuous),
    .STOP(stop), .SETTLE_CYCLES(settle_cycles), .AVG_SHIFT(avg_shift),
    .METRIC_IN(metric_in), .METRIC_VALID(metric_valid), .UPDATE_ACK(update_ack),
    .DAC_SEL(dac_sel), .J_PLUS(j_plus), .J_MINUS(j_minus), .DELTA_J(delta_j),
    .UPDATE_REQ(update_req), .BUSY(busy), .ITER_DONE(iter_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One run from IDLE: n_iter iterations, optional STOP in iteration stop_iter's U- averaging,
  // optional ENABLE drop at cycle abort_idx of the U- phase. ack_dly<0 holds ACK high throughout.
  task automatic run(input int settle, input int shift, input int vgap, input int ack_dly,
                     input bit cont, input int n_iter, input int stop_iter,
                     input bit start_spam, input int abort_idx);
    int cs, need, len, idx, exp_len, nval, iter, req_cyc;
    bit fin, valid;
    logic [1:0] dac, prev_dac, exp_next;
    logic [31:0] val;
    longint unsigned sum;
    longint d;
    cs = (shift > 8) ? 8 : shift;
    need = 1 << cs;
    len = 0; exp_len = 0; nval = 0; iter = 0; req_cyc = 0; fin = 0; sum = 0;
    prev_dac = dac_sel;
    settle_cycles = 16'(settle);
    avg_shift = 4'(shift);
    continuous = cont;
    update_ack = (ack_dly < 0);
    stop = 1'b0;
    metric_valid = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("busy_start", 64'(busy), 64'd1);
    for (int c = 0; c < 20000; c++) begin
      dac = dac_sel;
      if (dac !== prev_dac) begin
        case (prev_dac)
          2'b01: begin check("plus_len", 64'(len), 64'(exp_len)); plus_len = len; exp_next = 2'b10; end
          2'b10: begin check("minus_len", 64'(len), 64'(exp_len)); minus_len = len; exp_next = 2'b11; end
          default: exp_next = 2'b01;
        endcase
        check("dac_next", 64'(dac), 64'(exp_next));
        len = 0; nval = 0; sum = 0;
      end
      prev_dac = dac;
      idx = len;
      len++;

      if (iter_done) begin
        iter++;
        check("req_cycles", 64'(req_cyc), 64'((ack_dly < 0) ? 1 : ack_dly + 1));
        req_cyc = 0;
        if (iter == n_iter) begin
          check("end_busy", 64'(busy), 64'd0);
          check("end_dac", 64'(dac), 64'd3);
          check("end_req", 64'(update_req), 64'd0);
          fin = 1;
        end
      end
      if (fin) break;

      if (update_req) begin
        check("j_plus", 64'(j_plus), 64'(exp_jp));
        check("j_minus", 64'(j_minus), 64'(exp_jm));
        check("delta_j", 64'(delta_j), 64'(exp_dj));
        req_cyc++;
      end
      update_ack = (ack_dly < 0) ? 1'b1 : (update_req && (req_cyc - 1 >= ack_dly));
      stop  = cont && (iter == stop_iter - 1) && (dac == 2'b10) && (idx == settle + 1);
      start = start_spam && busy && ($urandom_range(0, 3) == 0);

      if (dac == 2'b01 || dac == 2'b10) begin
        if (abort_idx >= 0 && dac == 2'b10 && idx == abort_idx) begin
          enable = 1'b0;
          metric_valid = 1'b0;
          start = 1'b0;
          tick;
          check("abort_dac", 64'(dac_sel), 64'd0);
          check("abort_busy", 64'(busy), 64'd0);
          check("abort_req", 64'(update_req), 64'd0);
          check("abort_jp", 64'(j_plus), 64'(exp_jp));
          check("abort_jm", 64'(j_minus), 64'(exp_jm));
          check("abort_dj", 64'(delta_j), 64'(exp_dj));
          enable = 1'b1;
          tick;
          check("abort_idle_dac", 64'(dac_sel), 64'd0);
          return;
        end
        valid = (vgap == 0) ? 1'($urandom_range(0, 1)) : ((c % vgap) == 0);
        val = $urandom;
        if (idx > settle && valid && nval < need) begin
          if (dac == 2'b01 && pvals.size() > 0) val = pvals.pop_front();
          if (dac == 2'b10 && mvals.size() > 0) val = mvals.pop_front();
          sum += longint'(val);
          nval++;
          if (nval == need) begin
            exp_len = idx + 1;
            if (dac == 2'b01) exp_jp = 32'(sum >> cs);
            else begin
              exp_jm = 32'(sum >> cs);
              d = longint'(exp_jp) - longint'(exp_jm);
              exp_dj = 33'(d);
            end
          end
        end
        metric_in = val;
        metric_valid = valid;
      end else begin
        metric_in = $urandom;
        metric_valid = 1'($urandom_range(0, 1));
      end
      tick;
    end
    start = 1'b0;
    stop = 1'b0;
    if (!fin) check("iter_count", 64'(iter), 64'(n_iter));
    else begin
      tick;
      check("iter_done_pulse", 64'(iter_done), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int sh, ad, ni;
    bit ct;
    rst = 1'b1; enable = 1'b1; start = 1'b0; continuous = 1'b0; stop = 1'b0;
    settle_cycles = '0; avg_shift = '0; metric_in = '0; metric_valid = 1'b0; update_ack = 1'b0;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    check("rst_dac", 64'(dac_sel), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req", 64'(update_req), 64'd0);
    check("rst_jp", 64'(j_plus), 64'd0);
    check("rst_jm", 64'(j_minus), 64'd0);
    check("rst_dj", 64'(delta_j), 64'd0);

    // Directed single iteration with known samples.
    pvals = '{32'd100, 32'd102, 32'd104, 32'd106};
    mvals = '{32'd50, 32'd50, 32'd50, 32'd50};
    run(4, 2, 1, 3, 1'b0, 1, 0, 1'b0, -1);
    check("t2_jp", 64'(j_plus), 64'd103);
    check("t2_jm", 64'(j_minus), 64'd50);
    check("t2_dj", 64'(delta_j), 64'd53);
    check("t2_plus_len", 64'(plus_len), 64'd9);
    check("t2_minus_len", 64'(minus_len), 64'd9);
    check("t2_idle_dac", 64'(dac_sel), 64'd3);

    // Negative delta with sparse valid.
    pvals = '{32'd10};
    mvals = '{32'd30};
    run(0, 0, 3, 1, 1'b0, 1, 0, 1'b0, -1);
    check("t3_dj", 64'(delta_j), 64'h1_FFFF_FFEC);

    // Continuous run stopped during the second iteration.
    run(3, 1, 1, -1, 1'b1, 2, 2, 1'b0, -1);

    // ENABLE drop in U- settle, then a clean iteration.
    run(6, 2, 2, 0, 1'b0, 1, 0, 1'b0, 2);
    run(2, 1, 1, 1, 1'b0, 1, 0, 1'b0, -1);

    // START spam while busy, ACK held high before UPDATE.
    run(5, 2, 1, -1, 1'b0, 1, 0, 1'b1, -1);

    // Randomized runs, including clamped averaging exponents.
    for (int i = 0; i < 20; i++) begin
      sh = ($urandom_range(0, 9) == 0) ? 12 : int'($urandom_range(0, 9));
      ad = int'($urandom_range(0, 5)) - 1;
      ct = 1'($urandom_range(0, 1));
      ni = ct ? int'($urandom_range(1, 3)) : 1;
      run(int'($urandom_range(0, 8)), sh, int'($urandom_range(0, 2)), ad, ct, ni, ni,
          1'($urandom_range(0, 1)), -1);
    end

    // Reset mid-iteration returns everything to reset values.
    settle_cycles = 16'd10;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mid_rst_dac", 64'(dac_sel), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_jp", 64'(j_plus), 64'd0);
    check("mid_rst_jm", 64'(j_minus), 64'd0);
    check("mid_rst_dj", 64'(delta_j), 64'd0);
    tick;
    check("mid_rst_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
